// File: rtl/missile_collision_detector_if.sv
// missile_collision_detector_if
// Groups the per-pixel drawing requests, the frame marker and the collision
// results exchanged between the video pipeline and the collision detector.
//   startOfFrame   : one-cycle pulse at frame start (master -> slave)
//   missleDR, monsterDR, borderDR, shipDR, bombDR : drawing requests (master -> slave)
//   collision      : one-cycle report pulses, one bit per type (slave -> master)
//   frameCollision : types reported during the previous frame (slave -> master)
//   hitCount       : saturating count of missile-monster reports (slave -> master)
interface missile_collision_detector_if #(
  parameter int HIT_COUNT_WIDTH = 8
);
  logic                       startOfFrame;
  logic                       missleDR;
  logic                       monsterDR;
  logic                       borderDR;
  logic                       shipDR;
  logic                       bombDR;
  logic [3:0]                 collision;
  logic [3:0]                 frameCollision;
  logic [HIT_COUNT_WIDTH-1:0] hitCount;

  // The video pipeline drives the requests and consumes the results.
  modport master (
    output startOfFrame, missleDR, monsterDR, borderDR, shipDR, bombDR,
    input  collision, frameCollision, hitCount
  );

  // The collision detector consumes the requests and drives the results.
  modport slave (
    input  startOfFrame, missleDR, monsterDR, borderDR, shipDR, bombDR,
    output collision, frameCollision, hitCount
  );
endinterface

// File: rtl/missile_collision_detector.sv
// missile_collision_detector
// Detects per-pixel overlaps between game objects and reports each collision
// type at most once per frame, after MIN_OVERLAP_PIXELS overlapping pixels
// have accumulated within that frame.
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high; overrides every other event
//   bus   : slave side of missile_collision_detector_if
//           collision bits: 0 missile/monster, 1 missile/border,
//                           2 ship/bomb,       3 ship/monster
module missile_collision_detector #(
  parameter int MIN_OVERLAP_PIXELS = 2,
  parameter int HIT_COUNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  missile_collision_detector_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    REPORTED = 2'd2
  } state_e;

  localparam logic [8:0] MIN_CNT    = 9'(MIN_OVERLAP_PIXELS);
  localparam bit         MIN_IS_ONE = (MIN_OVERLAP_PIXELS == 1);

  logic [3:0]                 overlap_d;
  logic [3:0]                 overlap_q;
  state_e                     state_d [4];
  state_e                     state_q [4];
  logic [7:0]                 count_d [4];
  logic [7:0]                 count_q [4];
  logic [3:0]                 collision_d;
  logic [3:0]                 collision_q;
  logic [3:0]                 frameCollision_d;
  logic [3:0]                 frameCollision_q;
  logic [HIT_COUNT_WIDTH-1:0] hitCount_d;
  logic [HIT_COUNT_WIDTH-1:0] hitCount_q;

  // Within-frame progress of each type, ignoring the frame boundary.
  state_e                     normState [4];
  logic [7:0]                 normCount [4];
  logic [3:0]                 enterNorm;

  // Raw overlap per collision type for the pixel currently presented.
  always_comb begin
    overlap_d[0] = bus.missleDR & bus.monsterDR;
    overlap_d[1] = bus.missleDR & bus.borderDR;
    overlap_d[2] = bus.shipDR   & bus.bombDR;
    overlap_d[3] = bus.shipDR   & bus.monsterDR;
  end

  // Accumulate overlapping pixels inside the current frame. enterNorm marks
  // the edge at which a type would move into REPORTED if no frame boundary
  // intervened; the frame summary needs it even when the boundary wins.
  always_comb begin
    enterNorm = '0;
    for (int i = 0; i < 4; i++) begin
      normState[i] = state_q[i];
      normCount[i] = count_q[i];
      case (state_q[i])
        IDLE: begin
          if (overlap_q[i]) begin
            normCount[i] = 8'd1;
            if (MIN_IS_ONE) begin
              normState[i] = REPORTED;
              enterNorm[i] = 1'b1;
            end else begin
              normState[i] = COUNTING;
            end
          end
        end
        COUNTING: begin
          if (overlap_q[i]) begin
            if (count_q[i] != 8'hFF) begin
              normCount[i] = count_q[i] + 8'd1;
            end
            if (({1'b0, count_q[i]} + 9'd1) == MIN_CNT) begin
              normState[i] = REPORTED;
              enterNorm[i] = 1'b1;
            end
          end
        end
        REPORTED: begin
          normState[i] = REPORTED;
        end
        default: begin
          normState[i] = IDLE;
          normCount[i] = 8'd0;
        end
      endcase
    end
  end

  // A frame boundary snapshots the ending frame into frameCollision and then
  // restarts every type, with the pixel sampled on this same edge counted as
  // the first pixel of the new frame. A report completed only in the ending
  // frame therefore produces no pulse.
  always_comb begin
    collision_d      = '0;
    frameCollision_d = frameCollision_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = normState[i];
      count_d[i] = normCount[i];
      if (bus.startOfFrame) begin
        frameCollision_d[i] = (state_q[i] == REPORTED) | enterNorm[i];
        if (overlap_q[i]) begin
          count_d[i] = 8'd1;
          if (MIN_IS_ONE) begin
            state_d[i]     = REPORTED;
            collision_d[i] = 1'b1;
          end else begin
            state_d[i] = COUNTING;
          end
        end else begin
          state_d[i] = IDLE;
          count_d[i] = 8'd0;
        end
      end else begin
        collision_d[i] = enterNorm[i];
      end
    end
  end

  // Missile-monster reports are tallied from the registered pulse and stick
  // at all-ones instead of wrapping.
  always_comb begin
    hitCount_d = hitCount_q;
    if (collision_q[0] && (hitCount_q != {HIT_COUNT_WIDTH{1'b1}})) begin
      hitCount_d = hitCount_q + {{(HIT_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // All state and outputs; reset discards partial counts and anything
  // sampled while it is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      overlap_q        <= '0;
      collision_q      <= '0;
      frameCollision_q <= '0;
      hitCount_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        count_q[i] <= 8'd0;
      end
    end else begin
      overlap_q        <= overlap_d;
      collision_q      <= collision_d;
      frameCollision_q <= frameCollision_d;
      hitCount_q       <= hitCount_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  assign bus.collision      = collision_q;
  assign bus.frameCollision = frameCollision_q;
  assign bus.hitCount       = hitCount_q;

endmodule

// File: tb/tb_missile_collision_detector.sv
// tb_missile_collision_detector
// Directed bench for missile_collision_detector. Two instances share the same
// stimulus: dutOne uses a one-pixel threshold, dutTwo a two-pixel threshold.
// Each step drives one cycle of inputs, then samples 1 ns after the edge.
module tb_missile_collision_detector;

  logic clk;
  logic reset;
  logic sof, mis, mon, bor, shp, bmb;
  int   checks;
  int   errors;

  missile_collision_detector_if #(.HIT_COUNT_WIDTH(8)) ifOne ();
  missile_collision_detector_if #(.HIT_COUNT_WIDTH(8)) ifTwo ();

  assign ifOne.startOfFrame = sof;
  assign ifOne.missleDR     = mis;
  assign ifOne.monsterDR    = mon;
  assign ifOne.borderDR     = bor;
  assign ifOne.shipDR       = shp;
  assign ifOne.bombDR       = bmb;
  assign ifTwo.startOfFrame = sof;
  assign ifTwo.missleDR     = mis;
  assign ifTwo.monsterDR    = mon;
  assign ifTwo.borderDR     = bor;
  assign ifTwo.shipDR       = shp;
  assign ifTwo.bombDR       = bmb;

  missile_collision_detector #(.MIN_OVERLAP_PIXELS(1), .HIT_COUNT_WIDTH(8)) dutOne (
    .clk   (clk),
    .reset (reset),
    .bus   (ifOne.slave)
  );

  missile_collision_detector #(.MIN_OVERLAP_PIXELS(2), .HIT_COUNT_WIDTH(8)) dutTwo (
    .clk   (clk),
    .reset (reset),
    .bus   (ifTwo.slave)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs and move to just after the following edge.
  task automatic applyStimulus(input logic s, input logic m, input logic mn,
                               input logic b, input logic sh, input logic bm);
    sof = s; mis = m; mon = mn; bor = b; shp = sh; bmb = bm;
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mmStep();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sofStep();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleStep();
    idleStep();
    reset = 1'b0;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] observed,
                            input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare all three outputs of the selected instance (1 or 2).
  task automatic checkOutput(input string tag, input int d, input logic [3:0] expCol,
                             input logic [3:0] expFrame, input logic [7:0] expHit);
    logic [3:0] col;
    logic [3:0] frm;
    logic [7:0] hit;
    col = (d == 1) ? ifOne.collision      : ifTwo.collision;
    frm = (d == 1) ? ifOne.frameCollision : ifTwo.frameCollision;
    hit = (d == 1) ? ifOne.hitCount       : ifTwo.hitCount;
    checkValue({tag, ".collision"},      {4'b0, col}, {4'b0, expCol});
    checkValue({tag, ".frameCollision"}, {4'b0, frm}, {4'b0, expFrame});
    checkValue({tag, ".hitCount"},       hit,         expHit);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    sof = 1'b0; mis = 1'b0; mon = 1'b0; bor = 1'b0; shp = 1'b0; bmb = 1'b0;
    doReset();
    checkOutput("reset1", 1, 4'b0000, 4'b0000, 8'd0);
    checkOutput("reset2", 2, 4'b0000, 4'b0000, 8'd0);

    // Two consecutive missile-monster pixels, threshold two.
    sofStep();
    mmStep();
    mmStep();
    checkOutput("consec.pre", 2, 4'b0000, 4'b0000, 8'd0);
    idleStep();
    checkOutput("consec.pulse", 2, 4'b0001, 4'b0000, 8'd0);
    idleStep();
    checkOutput("consec.after", 2, 4'b0000, 4'b0000, 8'd1);
    idleStep();
    sofStep();
    checkOutput("consec.frame", 2, 4'b0000, 4'b0001, 8'd1);

    // Non-consecutive pixels accumulate; a third pixel gives no second pulse.
    mmStep();
    for (int k = 0; k < 9; k++) idleStep();
    mmStep();
    checkOutput("gap.pre", 2, 4'b0000, 4'b0001, 8'd1);
    idleStep();
    checkOutput("gap.pulse", 2, 4'b0001, 4'b0001, 8'd1);
    idleStep();
    checkOutput("gap.after", 2, 4'b0000, 4'b0001, 8'd2);
    mmStep();
    idleStep();
    checkOutput("gap.again1", 2, 4'b0000, 4'b0001, 8'd2);
    idleStep();
    checkOutput("gap.again2", 2, 4'b0000, 4'b0001, 8'd2);

    // Single border pixels on either side of a frame boundary never pair up.
    sofStep();
    checkOutput("border.frame0", 2, 4'b0000, 4'b0001, 8'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idleStep();
    sofStep();
    checkOutput("border.frame1", 2, 4'b0000, 4'b0000, 8'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idleStep();
    checkOutput("border.nopulse1", 2, 4'b0000, 4'b0000, 8'd2);
    idleStep();
    checkOutput("border.nopulse2", 2, 4'b0000, 4'b0000, 8'd2);
    sofStep();
    checkOutput("border.frame2", 2, 4'b0000, 4'b0000, 8'd2);

    // Threshold reached on the boundary edge: summary set, pulse suppressed,
    // and the boundary pixel restarts counting in the new frame.
    mmStep();
    mmStep();
    sofStep();
    checkOutput("sofEdge.suppress", 2, 4'b0000, 4'b0001, 8'd2);
    idleStep();
    checkOutput("sofEdge.quiet", 2, 4'b0000, 4'b0001, 8'd2);
    mmStep();
    idleStep();
    checkOutput("sofEdge.carry", 2, 4'b0001, 4'b0001, 8'd2);
    idleStep();
    checkOutput("sofEdge.hit", 2, 4'b0000, 4'b0001, 8'd3);

    // Reset mid-frame with overlap and startOfFrame held high.
    sofStep();
    checkOutput("midReset.frame", 2, 4'b0000, 4'b0001, 8'd3);
    mmStep();
    mmStep();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("midReset.cleared", 2, 4'b0000, 4'b0000, 8'd0);
    mmStep();
    checkOutput("midReset.wait1", 2, 4'b0000, 4'b0000, 8'd0);
    mmStep();
    checkOutput("midReset.wait2", 2, 4'b0000, 4'b0000, 8'd0);
    idleStep();
    checkOutput("midReset.pulse", 2, 4'b0001, 4'b0000, 8'd0);
    idleStep();
    checkOutput("midReset.hit", 2, 4'b0000, 4'b0000, 8'd1);

    // Threshold one: ship touching bomb and monster together.
    doReset();
    sofStep();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("ship.pre", 1, 4'b0000, 4'b0000, 8'd0);
    idleStep();
    checkOutput("ship.pulse", 1, 4'b1100, 4'b0000, 8'd0);
    idleStep();
    checkOutput("ship.after", 1, 4'b0000, 4'b0000, 8'd0);
    sofStep();
    checkOutput("ship.frame", 1, 4'b0000, 4'b1100, 8'd0);
    idleStep();
    idleStep();
    sofStep();
    checkOutput("ship.emptyFrame", 1, 4'b0000, 4'b0000, 8'd0);

    // Threshold one: boundary pixel pulses at once, then saturate hitCount.
    doReset();
    mmStep();
    sofStep();
    checkOutput("sat.sofPulse", 1, 4'b0001, 4'b0001, 8'd0);
    idleStep();
    checkOutput("sat.first", 1, 4'b0000, 4'b0001, 8'd1);
    for (int k = 0; k < 299; k++) begin
      sofStep();
      mmStep();
      idleStep();
      idleStep();
    end
    checkOutput("sat.full", 1, 4'b0000, 4'b0001, 8'd255);
    sofStep();
    mmStep();
    idleStep();
    checkOutput("sat.pulse", 1, 4'b0001, 4'b0001, 8'd255);
    idleStep();
    checkOutput("sat.hold", 1, 4'b0000, 4'b0001, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/missile_collision_detector.md
MISSILE_COLLISION_DETECTOR -- requirements
Module: missile_collision_detector

Interface
REQ-001 Parameter MIN_OVERLAP_PIXELS, default 2, is the overlapping pixels per frame needed to report a collision type; legal range 1..255.
REQ-002 Parameter HIT_COUNT_WIDTH, default 8, is the width of hitCount.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port startOfFrame  input  1  one-cycle pulse marking frame start.
REQ-006 Port missleDR  input  1  missile drawing request for the current pixel.
REQ-007 Port monsterDR  input  1  monster drawing request.
REQ-008 Port borderDR  input  1  border drawing request.
REQ-009 Port shipDR  input  1  spaceship drawing request.
REQ-010 Port bombDR  input  1  enemy bomb drawing request.
REQ-011 Port collision  output  4  one-cycle report pulses, one bit per type; drives the missile block collision input.
REQ-012 Port frameCollision  output  4  latched summary of the types reported in the previous frame.
REQ-013 Port hitCount  output  HIT_COUNT_WIDTH  saturating count of missile-monster reports.

Function
REQ-014 Type bits: bit0 missleDR&monsterDR; bit1 missleDR&borderDR; bit2 shipDR&bombDR; bit3 shipDR&monsterDR.
REQ-015 Raw overlap per type is registered into overlap_q on every edge, giving one cycle of input latency.
REQ-016 Each type has an independent FSM with states IDLE, COUNTING and REPORTED, plus a saturating pixel counter of 8 bits.
REQ-017 IDLE->COUNTING: first edge with overlap_q=1 in the frame, counter<=1; if MIN_OVERLAP_PIXELS=1, go directly to REPORTED instead.
REQ-018 COUNTING: each edge with overlap_q=1 increments the counter; the edge at which the counter reaches MIN_OVERLAP_PIXELS enters REPORTED.
REQ-019 Overlap pixels need not be consecutive; all pixels within one frame accumulate.
REQ-020 collision[i] is registered, and is 1 for exactly the one cycle following the edge that enters REPORTED; it is 0 at all other times.
REQ-021 REPORTED holds until a frame boundary; further overlaps in that state have no effect, giving at most one pulse per type per frame.
REQ-022 Overall latency is 2 cycles with MIN=1: inputs overlap in cycle c -> collision[i] high in cycle c+2. Each additional required pixel adds one overlapping cycle.
REQ-023 On an edge with startOfFrame=1, frameCollision[i] <= 1 iff type i is in REPORTED or enters REPORTED on that same edge (ending-frame value).
REQ-024 On that same edge, every FSM is reset to start a new frame and overlap_q at that edge counts as the first pixel of the new frame. The FSM goes to COUNTING with count 1, or to REPORTED with a pulse if MIN=1; otherwise it goes to IDLE with count 0.
REQ-025 Because of REQ-024, a report entering REPORTED on a startOfFrame edge through REQ-023 is counted only in the ending frame, and its pulse is suppressed unless it is re-triggered by the new-frame pixel.
REQ-026 frameCollision holds its value between startOfFrame edges.
REQ-027 hitCount increments by 1 on each edge at which collision[0] is asserted, and saturates at all-ones with no wrap.
REQ-028 Several types may pulse in the same cycle; each bit behaves independently.
REQ-029 Simultaneous multi-object requests are evaluated per REQ-014 only; no priority between objects.

Reset
REQ-030 While reset=1 at an edge: overlap_q, counters, collision, frameCollision and hitCount <= 0, and all FSMs go to IDLE.
REQ-031 reset has priority over startOfFrame and over overlap events on the same edge.
REQ-032 Reset mid-frame discards partial counts, and no pulse is produced for overlaps sampled during reset cycles.

Verification
REQ-033 MIN=2; missleDR=monsterDR=1 for cycles 10 and 11 -> collision=4'b0001 in cycle 13 only, hitCount=1 from cycle 14.
REQ-034 MIN=2; missile-monster overlap in cycles 10 and 20 of one frame (non-consecutive) -> single collision[0] pulse in cycle 22; overlap again in cycle 30 -> no pulse.
REQ-035 MIN=1; shipDR=bombDR=monsterDR=1 in cycle 5 -> collision=4'b1100 in cycle 7; next startOfFrame -> frameCollision=4'b1100, and 4'b0000 after the following frame with no overlaps.
REQ-036 MIN=2; one border overlap pixel, then startOfFrame, then one border pixel -> no collision[1] pulse and frameCollision[1]=0; counts do not carry across frames.
REQ-037 Force 300 missile-monster reports (MIN=1, one per frame) -> hitCount=255 and stays 255.
REQ-038 Mid-frame after one counted pixel (MIN=2), assert reset for 1 cycle with overlap held high -> all outputs 0. Counting restarts after reset, giving a pulse 2 overlapping cycles after reset deasserts plus latency.
